// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between NUM_CORES fetchers.
// One transaction in flight at a time; the response is routed back to the granted core.
module fetch_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int PC_ADDR_WIDTH  = 8,
  parameter int INST_MSG_WIDTH = 16,
  parameter int ID_WIDTH       = $clog2(NUM_CORES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CORES-1:0]               core_req_val,
  input  logic [NUM_CORES*PC_ADDR_WIDTH-1:0] core_req_addr,
  output logic [NUM_CORES-1:0]               core_req_rdy,
  output logic [NUM_CORES-1:0]               core_resp_val,
  input  logic [NUM_CORES-1:0]               core_resp_rdy,
  output logic [INST_MSG_WIDTH-1:0]          core_resp_inst,
  output logic                               mem_req_val,
  input  logic                               mem_req_rdy,
  output logic [PC_ADDR_WIDTH-1:0]           mem_req_addr,
  input  logic                               mem_resp_val,
  output logic                               mem_resp_rdy,
  input  logic [INST_MSG_WIDTH-1:0]          mem_resp_inst,
  output logic [1:0]                         arb_state,
  output logic [ID_WIDTH-1:0]                grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [ID_WIDTH-1:0]       last_grant_r;
  logic [ID_WIDTH-1:0]       grant_id_r;
  logic [PC_ADDR_WIDTH-1:0]  addr_r;
  logic [INST_MSG_WIDTH-1:0] inst_r;

  logic [ID_WIDTH-1:0]       winner_s;
  logic [ID_WIDTH-1:0]       cand_s;
  logic                      any_req_s;
  logic                      req_fire_s;
  logic                      resp_load_s;
  logic                      core_fire_s;

  function automatic logic [NUM_CORES-1:0] onehot(input logic [ID_WIDTH-1:0] id);
    logic [NUM_CORES-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

  // Round-robin search starting just past the last granted core, wrapping modulo NUM_CORES.
  always_comb begin
    winner_s  = '0;
    cand_s    = '0;
    any_req_s = 1'b0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand_s = ID_WIDTH'((int'(last_grant_r) + k) % NUM_CORES);
      if (!any_req_s && core_req_val[cand_s]) begin
        any_req_s = 1'b1;
        winner_s  = cand_s;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and handshake fire strobes.
  always_comb begin
    state_s     = state_r;
    req_fire_s  = 1'b0;
    resp_load_s = 1'b0;
    core_fire_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (any_req_s) begin
          req_fire_s = 1'b1;
          state_s    = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_rdy) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_resp_val) begin
          resp_load_s = 1'b1;
          state_s     = S_RESP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP: begin
        if (core_resp_rdy[grant_id_r]) begin
          core_fire_s = 1'b1;
          state_s     = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Transaction context: latched address/grant, returned instruction, round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r       <= '0;
      inst_r       <= '0;
      grant_id_r   <= '0;
      last_grant_r <= ID_WIDTH'(NUM_CORES - 1);
    end else begin
      if (req_fire_s) begin
        addr_r     <= core_req_addr[winner_s*PC_ADDR_WIDTH +: PC_ADDR_WIDTH];
        grant_id_r <= winner_s;
      end
      if (resp_load_s) begin
        inst_r <= mem_resp_inst;
      end
      if (core_fire_s) begin
        last_grant_r <= grant_id_r;
      end
    end
  end

  // Output decode: everything is a function of registered state except the IDLE accept.
  always_comb begin
    core_req_rdy   = '0;
    core_resp_val  = '0;
    core_resp_inst = '0;
    mem_req_val    = 1'b0;
    mem_req_addr   = '0;
    mem_resp_rdy   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (any_req_s) begin
          core_req_rdy = onehot(winner_s);
        end else begin
          core_req_rdy = '0;
        end
      end
      S_REQ: begin
        mem_req_val  = 1'b1;
        mem_req_addr = addr_r;
      end
      S_WAIT: begin
        mem_resp_rdy = 1'b1;
      end
      S_RESP: begin
        core_resp_val  = onehot(grant_id_r);
        core_resp_inst = inst_r;
      end
      default: begin
        core_req_rdy = '0;
      end
    endcase
  end

  assign arb_state = state_r;
  assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed self-checking bench for fetch_arbiter (4 cores, 8-bit PC, 16-bit instructions).
module tb_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_req_val;
  logic [31:0] core_req_addr;
  logic [3:0]  core_req_rdy;
  logic [3:0]  core_resp_val;
  logic [3:0]  core_resp_rdy;
  logic [15:0] core_resp_inst;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [7:0]  mem_req_addr;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [15:0] mem_resp_inst;
  logic [1:0]  arb_state;
  logic [1:0]  grant_id;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_arbiter #(
    .NUM_CORES(4), .PC_ADDR_WIDTH(8), .INST_MSG_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_val(core_req_val), .core_req_addr(core_req_addr), .core_req_rdy(core_req_rdy),
    .core_resp_val(core_resp_val), .core_resp_rdy(core_resp_rdy), .core_resp_inst(core_resp_inst),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_inst(mem_resp_inst),
    .arb_state(arb_state), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full-speed transaction; memory and core both ready. Starts in IDLE, ends in IDLE.
  task automatic txn(input int exp_id, input logic [7:0] exp_addr, input logic [15:0] inst);
    #1;
    check("rr_req_rdy", 32'(core_req_rdy), 32'(4'b0001 << exp_id));
    tick(); #1;
    check("rr_grant", 32'(grant_id), 32'(exp_id));
    check("rr_mem_addr", 32'(mem_req_addr), 32'(exp_addr));
    mem_resp_inst = inst;
    tick(); #1;
    check("rr_wait", 32'(mem_resp_rdy), 32'h1);
    tick(); #1;
    check("rr_resp_val", 32'(core_resp_val), 32'(4'b0001 << exp_id));
    check("rr_resp_inst", 32'(core_resp_inst), 32'(inst));
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    core_req_val  = 4'b0000;
    core_req_addr = 32'h0000_0000;
    core_resp_rdy = 4'b0000;
    mem_req_rdy   = 1'b0;
    mem_resp_val  = 1'b0;
    mem_resp_inst = 16'h0000;
    #3;
    check("rst_state", 32'(arb_state), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_mem_req_val", 32'(mem_req_val), 32'h0);
    check("rst_mem_addr", 32'(mem_req_addr), 32'h0);
    check("rst_mem_resp_rdy", 32'(mem_resp_rdy), 32'h0);
    check("rst_resp_val", 32'(core_resp_val), 32'h0);
    check("rst_resp_inst", 32'(core_resp_inst), 32'h0);
    check("rst_req_rdy", 32'(core_req_rdy), 32'h0);
    tick();
    reset = 1'b0;

    // Single requester: core 2, addr 0x1A, instruction 0x7C01.
    core_req_val  = 4'b0100;
    core_req_addr = {8'h00, 8'h1A, 8'h00, 8'h00};
    mem_req_rdy   = 1'b1;
    #1;
    check("s_c0_req_rdy", 32'(core_req_rdy), 32'h4);
    tick(); #1;
    check("s_c1_state", 32'(arb_state), 32'h1);
    check("s_c1_mem_val", 32'(mem_req_val), 32'h1);
    check("s_c1_mem_addr", 32'(mem_req_addr), 32'h1A);
    check("s_c1_req_rdy", 32'(core_req_rdy), 32'h0);
    check("s_c1_grant", 32'(grant_id), 32'h2);
    tick();
    mem_resp_val  = 1'b1;
    mem_resp_inst = 16'h7C01;
    #1;
    check("s_c2_state", 32'(arb_state), 32'h2);
    check("s_c2_mem_resp_rdy", 32'(mem_resp_rdy), 32'h1);
    check("s_c2_req_rdy", 32'(core_req_rdy), 32'h0);
    check("s_c2_resp_val", 32'(core_resp_val), 32'h0);
    tick();
    mem_resp_val  = 1'b0;
    core_resp_rdy = 4'b0100;
    #1;
    check("s_c3_resp_val", 32'(core_resp_val), 32'h4);
    check("s_c3_resp_inst", 32'(core_resp_inst), 32'h7C01);
    check("s_c3_req_rdy", 32'(core_req_rdy), 32'h0);
    check("s_c3_mem_resp_rdy", 32'(mem_resp_rdy), 32'h0);
    tick();
    core_req_val = 4'b0000;
    #1;
    check("s_c4_state", 32'(arb_state), 32'h0);
    check("s_c4_resp_val", 32'(core_resp_val), 32'h0);
    check("s_c4_resp_inst", 32'(core_resp_inst), 32'h0);
    check("s_c4_grant_hold", 32'(grant_id), 32'h2);
    check("s_c4_req_rdy", 32'(core_req_rdy), 32'h0);

    // Fresh reset so the pointer restarts at core 3; all four cores request.
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    core_req_val  = 4'b1111;
    core_req_addr = {8'h40, 8'h30, 8'h20, 8'h10};
    core_resp_rdy = 4'b1111;
    mem_req_rdy   = 1'b1;
    mem_resp_val  = 1'b1;
    txn(0, 8'h10, 16'hA000);
    txn(1, 8'h20, 16'hA001);
    txn(2, 8'h30, 16'hA002);
    txn(3, 8'h40, 16'hA003);
    txn(0, 8'h10, 16'hA004);

    // Round-robin skip: grant core 1, then only cores 0 and 3 request -> 3 then 0.
    core_req_val = 4'b0010;
    txn(1, 8'h20, 16'hB001);
    core_req_val = 4'b1001;
    txn(3, 8'h40, 16'hB003);
    txn(0, 8'h10, 16'hB000);

    // Memory backpressure: request held 5 cycles, response delayed 3 cycles.
    core_req_val = 4'b0100;
    mem_req_rdy  = 1'b0;
    mem_resp_val = 1'b0;
    #1;
    check("bp_req_rdy", 32'(core_req_rdy), 32'h4);
    tick();
    core_req_val = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_req_state", 32'(arb_state), 32'h1);
      check("bp_req_val", 32'(mem_req_val), 32'h1);
      check("bp_req_addr", 32'(mem_req_addr), 32'h30);
      tick();
    end
    mem_req_rdy = 1'b1;
    #1;
    check("bp_req_state_last", 32'(arb_state), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_wait_state", 32'(arb_state), 32'h2);
      check("bp_wait_resp_val", 32'(core_resp_val), 32'h0);
      tick();
    end
    mem_resp_val  = 1'b1;
    mem_resp_inst = 16'hBEEF;
    #1;
    check("bp_wait_state_last", 32'(arb_state), 32'h2);
    tick();
    mem_resp_val = 1'b0;
    #1;
    check("bp_resp_val", 32'(core_resp_val), 32'h4);
    check("bp_resp_inst", 32'(core_resp_inst), 32'hBEEF);
    tick();

    // Core response backpressure: core 1 granted and stalls; core 0 toggles its ready.
    core_req_val  = 4'b0010;
    core_resp_rdy = 4'b0000;
    mem_resp_val  = 1'b1;
    mem_resp_inst = 16'h1234;
    #1;
    check("cb_req_rdy", 32'(core_req_rdy), 32'h2);
    tick();
    core_req_val = 4'b1011;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      core_resp_rdy = i[0] ? 4'b1001 : 4'b0000;
      #1;
      check("cb_state", 32'(arb_state), 32'h3);
      check("cb_resp_val", 32'(core_resp_val), 32'h2);
      check("cb_resp_inst", 32'(core_resp_inst), 32'h1234);
      check("cb_req_rdy_stall", 32'(core_req_rdy), 32'h0);
      check("cb_grant", 32'(grant_id), 32'h1);
      tick();
    end
    core_resp_rdy = 4'b0010;
    #1;
    check("cb_state_last", 32'(arb_state), 32'h3);
    tick();
    #1;
    check("cb_next_winner", 32'(core_req_rdy), 32'h8);
    core_req_val = 4'b0000;
    mem_resp_val = 1'b0;

    // Reset while waiting for memory; a late response must be ignored.
    core_req_val  = 4'b0001;
    core_resp_rdy = 4'b1111;
    mem_req_rdy   = 1'b1;
    #1;
    check("rw_req_rdy", 32'(core_req_rdy), 32'h1);
    tick();
    core_req_val = 4'b0000;
    tick();
    #1;
    check("rw_in_wait", 32'(arb_state), 32'h2);
    reset = 1'b1;
    #1;
    check("rw_rst_state", 32'(arb_state), 32'h0);
    check("rw_rst_mem_resp_rdy", 32'(mem_resp_rdy), 32'h0);
    check("rw_rst_grant", 32'(grant_id), 32'h0);
    check("rw_rst_mem_val", 32'(mem_req_val), 32'h0);
    tick();
    reset         = 1'b0;
    mem_resp_val  = 1'b1;
    mem_resp_inst = 16'hDEAD;
    #1;
    check("rw_late_resp_rdy", 32'(mem_resp_rdy), 32'h0);
    check("rw_late_state", 32'(arb_state), 32'h0);
    tick();
    #1;
    check("rw_ignored_state", 32'(arb_state), 32'h0);
    check("rw_ignored_resp_val", 32'(core_resp_val), 32'h0);
    check("rw_ignored_inst", 32'(core_resp_inst), 32'h0);
    mem_resp_val = 1'b0;
    core_req_val = 4'b1111;
    #1;
    check("rw_first_winner", 32'(core_req_rdy), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_arbiter.md
Name: fetch_arbiter

Overview:
Round-robin arbiter that shares one instruction-memory port between NUM_CORES fetcher units. Each fetcher connects its fetch request/response val/rdy channels here instead of directly to memory. The arbiter keeps one transaction outstanding at a time and routes the returned instruction back to the requester that was granted. It sits between the per-core fetchers and the instruction memory.

Parameters:
NUM_CORES, 4, number of requesting fetchers (>=2)
PC_ADDR_WIDTH, 8, instruction address width
INST_MSG_WIDTH, 16, instruction word width
ID_WIDTH, $clog2(NUM_CORES), width of grant index

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
core_req_val  input  NUM_CORES  per-core fetch request valid
core_req_addr  input  NUM_CORES*PC_ADDR_WIDTH  per-core PC; core i occupies bits [i*PC_ADDR_WIDTH +: PC_ADDR_WIDTH]
core_req_rdy  output  NUM_CORES  per-core request accept
core_resp_val  output  NUM_CORES  per-core response valid (one-hot or zero)
core_resp_rdy  input  NUM_CORES  per-core response ready
core_resp_inst  output  INST_MSG_WIDTH  returned instruction, shared bus
mem_req_val  output  1  memory request valid
mem_req_rdy  input  1  memory request ready
mem_req_addr  output  PC_ADDR_WIDTH  memory request address
mem_resp_val  input  1  memory response valid
mem_resp_rdy  output  1  memory response ready
mem_resp_inst  input  INST_MSG_WIDTH  memory response data
arb_state  output  2  FSM state (debug)
grant_id  output  ID_WIDTH  index of the currently granted core

Behaviour:
- States (arb_state encoding): IDLE=0, REQ=1, WAIT=2, RESP=3.
- Reset (async, immediate): state=IDLE; last_grant=NUM_CORES-1; grant_id=0; latched addr/inst=0. All val/rdy outputs=0, core_resp_inst=0, mem_req_addr=0.
- IDLE: winner = first core with core_req_val set, searching from last_grant+1 upward with wrap modulo NUM_CORES. core_req_rdy is combinational: 1 only at bit [winner], and only when any core_req_val is high. On fire: latch addr and winner into grant_id, go to REQ. If no request is valid, stay in IDLE with all rdy=0.
- REQ: mem_req_val=1, mem_req_addr=latched addr. Hold both stable until mem_req_rdy. On fire, go to WAIT.
- WAIT: mem_resp_rdy=1. On mem_resp_val, latch mem_resp_inst and go to RESP. mem_resp_rdy=0 in every other state, so stray responses are not accepted.
- RESP: core_resp_val[grant_id]=1 and core_resp_inst=latched inst; other core_resp_val bits are 0. Hold until core_resp_rdy[grant_id]; ready bits of non-granted cores are ignored. On fire: last_grant<=grant_id, go to IDLE.
- core_req_rdy is 0 in every state except IDLE, so new requests stall during a transaction.
- core_resp_inst is 0 outside RESP.
- Minimum turnaround with memory ready and core ready: accept at cycle 0, mem_req_val at cycle 1, response accepted at cycle 2, core_resp_val at cycle 3, next grant at cycle 4.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 transactions.
- Reset mid-transaction: state is dropped. A memory response arriving after reset is not accepted, because mem_resp_rdy=0 in IDLE.
- grant_id holds its last value while in IDLE.

Test Plan:
- Single requester: core 2 requests addr 0x1A; memory returns 0x7C01 in the same cycle as mem_resp_rdy -> mem_req_addr=0x1A at cycle 1; core_resp_val=4'b0100 and core_resp_inst=0x7C01 at cycle 3; core_req_rdy=0 during cycles 1-3.
- Simultaneous requests: all 4 cores hold val with addrs 0x10/0x20/0x30/0x40 after reset -> grant order 0,1,2,3,0; mem_req_addr sequence 0x10,0x20,0x30,0x40,0x10.
- Round-robin skip: last_grant=1; only cores 0 and 3 request -> core 3 granted first, then core 0.
- Memory backpressure: mem_req_rdy low for 5 cycles -> mem_req_val and mem_req_addr stay stable and state stays REQ. mem_resp_val is delayed 3 cycles -> state stays WAIT; no core_resp_val is raised before the data arrives.
- Core response backpressure: granted core 1 holds core_resp_rdy=0 for 4 cycles while core 0 toggles its resp_rdy -> core_resp_val=4'b0010 is held stable with the same inst; no new grant is made and core_req_rdy=0.
- Reset in WAIT: assert reset, then present mem_resp_val=1 on the next cycle -> outputs go to zero immediately; mem_resp_rdy=0 and the response is ignored; after reset, core 0 wins first.
